// File: rtl/seq_detect_prog_if.sv
// Signal bundle for the programmable serial sequence detector: config, serial input,
// and result outputs.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               enable;
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               detect;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output enable, in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        input  detect, match_count, cfg_err
    );

    modport slave (
        input  enable, in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        output detect, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap/non-overlap modes and a
// saturating match counter.
//   state | meaning
//   IDLE  | enable low, history and fill frozen
//   FILL  | fewer than len bits collected since the last clear
//   ARMED | at least len bits collected, every sampled bit can complete a match
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             reset,
    seq_detect_prog_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pattern, pattern_n, hist, hist_n, hist_shift, mask;
    logic [LEN_W-1:0]   len, len_n, fill, fill_n, fill_inc;
    logic               overlap, overlap_n;
    logic               detect, detect_n, cfg_err, cfg_err_n;
    logic [CNT_W-1:0]   count, count_n;
    logic               sample, cfg_ok, match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pattern <= MAX_LEN'(4'b1101);
            len     <= LEN_W'(4);
            overlap <= 1'b0;
            hist    <= '0;
            fill    <= '0;
            detect  <= 1'b0;
            cfg_err <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_n;
            pattern <= pattern_n;
            len     <= len_n;
            overlap <= overlap_n;
            hist    <= hist_n;
            fill    <= fill_n;
            detect  <= detect_n;
            cfg_err <= cfg_err_n;
            count   <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        pattern_n  = pattern;
        len_n      = len;
        overlap_n  = overlap;
        hist_n     = hist;
        fill_n     = fill;
        cfg_err_n  = cfg_err;
        count_n    = count;

        sample     = bus.enable & bus.in_valid & ~bus.cfg_load;
        cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
        // shifting by len == MAX_LEN leaves zero, so the mask becomes all ones
        mask       = ~({MAX_LEN{1'b1}} << len);
        hist_shift = {hist[MAX_LEN-2:0], bus.in_bit};
        fill_inc   = (fill < len) ? fill + 1'b1 : fill;
        match      = sample && (fill_inc >= len) && ((hist_shift & mask) == (pattern & mask));
        detect_n   = match;

        if (bus.cfg_load) begin
            if (cfg_ok) begin
                pattern_n = bus.cfg_pattern;
                len_n     = bus.cfg_len;
                overlap_n = bus.cfg_overlap;
                hist_n    = '0;
                fill_n    = '0;
                cfg_err_n = 1'b0;
            end else begin
                cfg_err_n = 1'b1;
            end
        end else if (sample) begin
            hist_n = hist_shift;
            fill_n = (match && !overlap) ? '0 : fill_inc;
        end

        if (bus.count_clr)
            count_n = match ? CNT_W'(1) : '0;
        else if (match && (count != '1))
            count_n = count + 1'b1;

        if (!bus.enable)
            state_n = IDLE;
        else if (fill_n >= len_n)
            state_n = ARMED;
        else
            state_n = FILL;
    end

    assign bus.detect      = detect;
    assign bus.match_count = count;
    assign bus.cfg_err     = cfg_err;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: stimulus pushes expected detect values,
// a negedge monitor pops and compares them.
module tb_seq_detect_prog;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(16)) bus ();
    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2))  bus2 ();

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.enable      = bus.enable;
    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_bit      = bus.in_bit;
    assign bus2.cfg_load    = bus.cfg_load;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_overlap = bus.cfg_overlap;
    assign bus2.count_clr   = bus.count_clr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            check("detect", {31'd0, bus.detect}, {31'd0, e});
        end
    end

    task automatic cyc(input logic en, input logic v, input logic b, input logic exp_det);
        @(negedge clk);
        bus.enable   = en;
        bus.in_valid = v;
        bus.in_bit   = b;
        @(posedge clk);
        exp_q.push_back(exp_det);
        #1;
        bus.in_valid  = 1'b0;
        bus.cfg_load  = 1'b0;
        bus.count_clr = 1'b0;
    endtask

    // a valid bit rides along with every load to show it is dropped
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic clr);
        @(negedge clk);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.count_clr   = clr;
        bus.in_valid    = 1'b1;
        bus.in_bit      = 1'b1;
        @(posedge clk);
        exp_q.push_back(1'b0);
        #1;
        bus.in_valid  = 1'b0;
        bus.cfg_load  = 1'b0;
        bus.count_clr = 1'b0;
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--)
            cyc(1'b1, 1'b1, bits[i], exp[i]);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        drain();
        reset = 1'b1;
        #1;
        check("rst_detect", {31'd0, bus.detect}, 32'd0);
        check("rst_count", {16'd0, bus.match_count}, 32'd0);
        check("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_overlap = 1'b0; bus.count_clr = 1'b0;
        repeat (2) @(negedge clk);

        // default 1101, non-overlap
        do_reset();
        stream(16'b1101101, 7, 16'b0001000);
        drain();
        check("s1_count", {16'd0, bus.match_count}, 32'd1);

        // overlap mode, counter cleared alongside the load
        load(8'b1101, 4'd4, 1'b1, 1'b1);
        stream(16'b1101101, 7, 16'b0001001);
        drain();
        check("s2_count", {16'd0, bus.match_count}, 32'd2);

        load(8'b11, 4'd2, 1'b1, 1'b1);
        stream(16'b1111, 4, 16'b0111);
        drain();
        check("s3_ov_count", {16'd0, bus.match_count}, 32'd3);
        load(8'b11, 4'd2, 1'b0, 1'b1);
        stream(16'b1111, 4, 16'b0101);
        drain();
        check("s3_nov_count", {16'd0, bus.match_count}, 32'd2);

        // gaps from in_valid=0, then from enable=0 with junk valid bits
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        stream(16'b101, 3, 16'b001);
        drain();
        check("s4_gap_count", {16'd0, bus.match_count}, 32'd1);
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        stream(16'b101, 3, 16'b001);
        drain();
        check("s4_en_count", {16'd0, bus.match_count}, 32'd1);

        // rejected configs keep the default pattern
        do_reset();
        load(8'hFF, 4'd0, 1'b1, 1'b0);
        drain();
        check("s5_err_len0", {31'd0, bus.cfg_err}, 32'd1);
        load(8'hFF, 4'd9, 1'b1, 1'b0);
        drain();
        check("s5_err_len9", {31'd0, bus.cfg_err}, 32'd1);
        stream(16'b1101, 4, 16'b0001);
        drain();
        check("s5_count", {16'd0, bus.match_count}, 32'd1);
        load(8'b1101, 4'd4, 1'b0, 1'b0);
        drain();
        check("s5_err_clr", {31'd0, bus.cfg_err}, 32'd0);
        check("s5_count_kept", {16'd0, bus.match_count}, 32'd1);

        // reset in the middle of a partial pattern
        do_reset();
        stream(16'b110, 3, 16'b000);
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        check("s6_count", {16'd0, bus.match_count}, 32'd0);

        // saturation on the 2-bit counter and clear-on-match
        do_reset();
        load(8'b11, 4'd2, 1'b1, 1'b0);
        stream(16'b111111, 6, 16'b011111);
        drain();
        check("s7_sat", {30'd0, bus2.match_count}, 32'd3);
        check("s7_wide", {16'd0, bus.match_count}, 32'd5);
        bus.count_clr = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        drain();
        check("s7_clr_sat", {30'd0, bus2.match_count}, 32'd1);
        check("s7_clr_wide", {16'd0, bus.match_count}, 32'd1);

        drain();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
